uart_rx_os16: RTL and testbench

Oversampling UART receive front end. Recovers 8N1 bytes from the asynchronous `rx` pin using 16× oversampling and 3-sample majority voting, and validates the start and stop bits. Each received byte is presented on a single-entry valid/ready output register. The block sits directly upstream of the byte-collect/retransmit stage, which consumes `rx_data` through the handshake instead of sampling `rx` itself.

---
 rtl/uart_rx_os16.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_os16.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority voting.
// Received bytes are held in a single-entry valid/ready output register.
module uart_rx_os16 #(
  parameter int FREQ = 12000000,
  parameter int BAUD = 9600,
  parameter int DIV  = FREQ / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int              DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  localparam logic [3:0] T_SAMPLE_A = 4'd7;
  localparam logic [3:0] T_SAMPLE_B = 4'd8;
  localparam logic [3:0] T_DECIDE   = 4'd9;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       t_q, t_d;
  logic [1:0]       samp_q, samp_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic       rxs;
  logic       tick;
  logic [3:0] t_cur;
  logic       maj;
  logic       decide;
  logic       deliver;

  assign rxs    = sync2_q;
  assign tick   = (state_q != S_IDLE) && (div_q == DIV_MAX);
  // t_q holds the previous tick's index, so t_cur is the index of the tick firing now.
  assign t_cur  = t_q + 4'd1;
  assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
  assign decide = tick && (t_cur == T_DECIDE);

  always_comb begin
    // NOTE: every _d gets a default before any branch so no path leaves it unassigned (no latches).
    sync1_d     = rx;
    sync2_d     = sync1_q;
    state_d     = state_q;
    div_d       = div_q;
    t_d         = t_q;
    samp_d      = samp_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;

    if (state_q == S_IDLE || tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (tick) begin
      t_d = t_cur;
      if (t_cur == T_SAMPLE_A) samp_d[0] = rxs;
      if (t_cur == T_SAMPLE_B) samp_d[1] = rxs;
    end

    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          t_d     = 4'd0;
        end
      end
      S_START: begin
        if (decide) begin
          if (maj) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (decide) begin
          shift_d = {maj, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (decide) begin
          if (maj) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        // A held-low line (break) must return high before a new start is accepted.
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (deliver) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!nrst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      div_q       <= '0;
      t_q         <= 4'd0;
      samp_q      <= 2'b00;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      div_q       <= div_d;
      t_q         <= t_d;
      samp_q      <= samp_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: frame-level event model checked every cycle,
// plus literal timing/data expectations for each directed scenario.
module tb_uart_rx_os16;

  localparam int BIT_CYC = 160;
  localparam int LAT     = 1531;

  logic       clk;
  logic       nrst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_os16 #(.FREQ(1600000), .BAUD(10000)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic rdy_s  = 1'b1;
  logic nrst_s = 1'b1;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rdy_s  <= rx_ready;
    nrst_s <= nrst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Frame-level model: each frame yields one outcome at a known cycle and a busy window.
  typedef struct { int at; bit err; logic [7:0] data; } ev_t;
  typedef struct { int lo; int hi; } win_t;
  ev_t  ev_q[$];
  win_t win_q[$];
  int   last_d = 0;

  bit         armed = 0;
  logic       m_valid;
  logic [7:0] m_data;
  int valid_rises = 0, last_valid_rise = 0;
  int fe_cnt = 0, last_fe = 0, ov_cnt = 0, last_ov = 0, last_busy_fall = 0;
  logic prev_valid = 1'b0, prev_busy = 1'b0;

  initial begin
    logic busy_e, fe_e, ov_e;
    ev_t  ev;
    forever begin
      @(negedge clk);
      busy_e = 1'b0; fe_e = 1'b0; ov_e = 1'b0;
      if (nrst_s === 1'b0) begin
        armed   = 1;
        m_valid = 1'b0;
        m_data  = 8'h00;
        ev_q.delete();
        win_q.delete();
      end else if (armed) begin
        while (win_q.size() > 0 && win_q[0].hi < cyc) void'(win_q.pop_front());
        busy_e = (win_q.size() > 0) && (win_q[0].lo <= cyc);
        if (ev_q.size() > 0 && ev_q[0].at == cyc) begin
          ev = ev_q.pop_front();
          fe_e = ev.err;
          if (!ev.err) begin
            if (!m_valid || rdy_s) begin
              m_valid = 1'b1;
              m_data  = ev.data;
            end else begin
              ov_e = 1'b1;
            end
          end else if (m_valid && rdy_s) begin
            m_valid = 1'b0;
          end
        end else if (m_valid && rdy_s) begin
          m_valid = 1'b0;
        end
      end
      if (armed) begin
        check("outputs", 32'({busy, frame_err, overrun, rx_valid, rx_data}),
              32'({busy_e, fe_e, ov_e, m_valid, m_data}));
        if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin
          valid_rises++;
          last_valid_rise = cyc;
        end
        if (frame_err === 1'b1) begin fe_cnt++; last_fe = cyc; end
        if (overrun === 1'b1) begin ov_cnt++; last_ov = cyc; end
        if (busy === 1'b0 && prev_busy === 1'b1) last_busy_fall = cyc;
        prev_valid = rx_valid;
        prev_busy  = busy;
      end
    end
  end

  // Drives one 8N1 frame; a 0 stop bit is followed by hold_low extra low cycles.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input int hold_low, output int d_cyc);
    int n;
    @(negedge clk);
    n      = cyc;
    d_cyc  = n + 2;
    last_d = d_cyc;
    ev_q.push_back('{at: d_cyc + LAT, err: !stop_bit, data: data});
    win_q.push_back('{lo: d_cyc + 1,
                      hi: stop_bit ? d_cyc + LAT - 1 : n + 10 * BIT_CYC + hold_low + 2});
    rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT_CYC) @(negedge clk);
    if (!stop_bit) begin
      repeat (hold_low) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    int d, n, r0, f0, o0;
    nrst = 1'b0; rx = 1'b1; rx_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_outputs", 32'({rx_data, rx_valid, frame_err, overrun, busy}), 32'd0);
    nrst = 1'b1;
    repeat (20) @(negedge clk);

    // 1: plain byte
    send_frame(8'hA5, 1'b1, 0, d);
    repeat (10) @(negedge clk);
    check("t1_valid_rise", last_valid_rise - d, LAT);
    check("t1_data", 32'(rx_data), 32'hA5);
    check("t1_no_frame_err", fe_cnt, 0);
    check("t1_no_overrun", ov_cnt, 0);

    // 2: start glitch, then a real byte
    r0 = valid_rises;
    @(negedge clk);
    n = cyc; d = n + 2;
    win_q.push_back('{lo: d + 1, hi: d + 90});
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("t2_busy_fall", last_busy_fall - d, 91);
    check("t2_no_valid", valid_rises, r0);
    send_frame(8'h3C, 1'b1, 0, d);
    repeat (10) @(negedge clk);
    check("t2_data", 32'(rx_data), 32'h3C);
    check("t2_valid_rise", last_valid_rise - d, LAT);

    // 3: framing error with break, then recovery
    r0 = valid_rises; f0 = fe_cnt;
    send_frame(8'h55, 1'b0, 3 * BIT_CYC, d);
    check("t3_one_frame_err", fe_cnt - f0, 1);
    check("t3_frame_err_cyc", last_fe - d, LAT);
    check("t3_no_valid", valid_rises, r0);
    check("t3_busy_fall", last_busy_fall - d, 2081);
    send_frame(8'h01, 1'b1, 0, d);
    repeat (10) @(negedge clk);
    check("t3_next_data", 32'(rx_data), 32'h01);

    // 4: overrun with consumer stalled
    rx_ready = 1'b0;
    o0 = ov_cnt;
    send_frame(8'h11, 1'b1, 0, d);
    send_frame(8'h22, 1'b1, 0, d);
    repeat (10) @(negedge clk);
    check("t4_one_overrun", ov_cnt - o0, 1);
    check("t4_overrun_cyc", last_ov - d, LAT);
    check("t4_kept_data", 32'(rx_data), 32'h11);
    check("t4_valid_held", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    @(negedge clk);
    check("t4_valid_cleared", 32'(rx_valid), 32'd0);

    // 5: ready coincides with a new delivery
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 0, d);
    o0 = ov_cnt;
    fork
      send_frame(8'h22, 1'b1, 0, d);
      begin
        repeat (2) @(negedge clk);
        while (cyc < last_d + LAT - 1) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("t5_data", 32'(rx_data), 32'h22);
        check("t5_valid", 32'(rx_valid), 32'd1);
      end
    join
    check("t5_no_overrun", ov_cnt, o0);
    rx_ready = 1'b1;
    repeat (5) @(negedge clk);

    // 6: reset during data bit 4 of 0xF0, then a clean byte
    @(negedge clk);
    n = cyc;
    ev_q.push_back('{at: n + 2 + LAT, err: 1'b0, data: 8'hF0});
    win_q.push_back('{lo: n + 3, hi: n + 1 + LAT});
    rx = 1'b0;
    repeat (5 * BIT_CYC) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CYC / 2) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    check("t6_reset_outputs", 32'({rx_data, rx_valid, frame_err, overrun, busy}), 32'd0);
    repeat (4 * BIT_CYC) @(negedge clk);
    check("t6_idle_after_reset", 32'(busy), 32'd0);
    send_frame(8'h0F, 1'b1, 0, d);
    repeat (10) @(negedge clk);
    check("t6_data", 32'(rx_data), 32'h0F);
    check("t6_valid_rise", last_valid_rise - d, LAT);

    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
